// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating priority search for the four-requester arbiter.
// The search result carries both the winning index and a found flag.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req, scanning start, start+1, ... with 2-bit wraparound.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   start);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_enc_4to2.sv
// One-hot to binary encoder for the next-cycle grant vector.
// An all-zero input encodes to 2'b00 so an idle arbiter reports index 0.
module onehot_enc_4to2
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_onehot,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold limit that lets a waiting
// requester preempt an owner after MAX_HOLD consecutive cycles of ownership.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid,
    output logic                 preempt
);

    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]    r_grant_idx;
    logic                r_grant_valid;
    logic                r_preempt;

    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_preempt_nxt;
    logic                w_take;
    logic [IDX_W-1:0]    w_take_idx;
    pick_t               w_pick_idle;
    pick_t               w_pick_next;

    // In GRANT the owner is masked out so the search never re-picks it.
    assign w_pick_idle = rr_pick(req, r_ptr);
    assign w_pick_next = rr_pick(req & ~r_grant, r_grant_idx + IDX_W'(1));

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_hold_cnt;
        w_grant_nxt   = r_grant;
        w_preempt_nxt = 1'b0;
        w_take        = 1'b0;
        w_take_idx    = '0;

        unique case (r_state)
            IDLE: begin
                if (w_pick_idle.found) begin
                    w_take     = 1'b1;
                    w_take_idx = w_pick_idle.idx;
                end
            end
            GRANT: begin
                if (!req[r_grant_idx]) begin
                    // Release has priority over preemption, so no pulse here.
                    if (w_pick_next.found) begin
                        w_take     = 1'b1;
                        w_take_idx = w_pick_next.idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end else if (PREEMPT_EN && r_hold_cnt == HOLD_LIM && w_pick_next.found) begin
                    w_take        = 1'b1;
                    w_take_idx    = w_pick_next.idx;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt < HOLD_LIM) begin
                    w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase

        if (w_take) begin
            w_state_nxt = GRANT;
            w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_take_idx;
            w_ptr_nxt   = w_take_idx + IDX_W'(1);
            w_cnt_nxt   = CNT_W'(1);
        end
    end

    onehot_enc_4to2 u_enc (
        .i_onehot (w_grant_nxt),
        .o_idx    (w_idx_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_preempt     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hold_cnt    <= w_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_preempt     <= w_preempt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign preempt     = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: vector table, directed corner cases,
// and randomized traffic compared against an integer-level round-robin model.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int n_checks = 0;
    int n_pass   = 0;

    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_pre;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       p;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_inv(input string tag);
        int   ones;
        logic [1:0] enc;
        ones = 0;
        enc  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                ones++;
                enc = 2'(i);
            end
        end
        check({tag, "_onehot0"}, 32'(ones <= 1), 32'h1);
        check({tag, "_idx_enc"}, 32'(grant_idx), 32'(enc));
        check({tag, "_valid_or"}, 32'(grant_valid), 32'(ones != 0));
    endtask

    // Reference model: owner as an integer, -1 meaning idle.
    function automatic int first_from(input logic [3:0] r, input int start, input int skip);
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (start + k) % 4;
            if (c != skip && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % 4;
        m_cnt   = 1;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = first_from(r, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else begin
            w = first_from(r, m_owner + 1, m_owner);
            if (!r[m_owner]) begin
                if (w >= 0) model_grant(w);
                else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD && w >= 0) begin
                model_grant(w);
                m_pre = 1'b1;
            end else if (m_cnt < MAX_HOLD) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("rnd_grant", 32'(grant), 32'(eg));
        check("rnd_idx", 32'(grant_idx), (m_owner < 0) ? 32'h0 : 32'(m_owner));
        check("rnd_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("rnd_preempt", 32'(preempt), 32'(m_pre));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        logic [3:0] r;
        int         held;
        bit         done;

        vecs[0] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6] = '{4'b1100, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[8] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Vector table: single grants, release to idle, pointer advance.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req;
            step();
            check("tbl_grant", 32'(grant), 32'(vecs[i].g));
            check("tbl_idx", 32'(grant_idx), 32'(vecs[i].idx));
            check("tbl_valid", 32'(grant_valid), 32'(vecs[i].v));
            check("tbl_preempt", 32'(preempt), 32'(vecs[i].p));
        end

        // All four requesting, each owner leaving after two cycles.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            req = 4'b1111;
            check("rot_grant_first", 32'(grant), 32'(exp_g));
            check("rot_preempt", 32'(preempt), 32'h0);
            step();
            check("rot_grant_hold", 32'(grant), 32'(exp_g));
            req = 4'b1111 & ~exp_g;
        end

        // Hold limit: owner 1 is preempted by requester 3 after exactly 8 cycles.
        do_reset();
        req = 4'b0010;
        step();
        check("hold_first", 32'(grant), 32'h2);
        held = 1;
        done = 1'b0;
        for (int c = 1; c < 40 && !done; c++) begin
            if (c == 3) req = 4'b1010;
            step();
            if (grant == 4'b0010) held++;
            else done = 1'b1;
        end
        check("hold_cycles", 32'(held), 32'd8);
        check("hold_pre_grant", 32'(grant), 32'h8);
        check("hold_pre_idx", 32'(grant_idx), 32'd3);
        check("hold_pre_pulse", 32'(preempt), 32'h1);
        step();
        check("hold_pulse_end", 32'(preempt), 32'h0);
        check("hold_new_owner", 32'(grant), 32'h8);

        // Lone requester keeps the grant; saturated counter allows immediate preempt.
        do_reset();
        req = 4'b0100;
        step();
        for (int c = 0; c < 30; c++) begin
            step();
            check("solo_grant", 32'(grant), 32'h4);
            check("solo_preempt", 32'(preempt), 32'h0);
        end
        req = 4'b0101;
        step();
        check("sat_grant", 32'(grant), 32'h1);
        check("sat_preempt", 32'(preempt), 32'h1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b1000;
        step();
        check("mid_owner3", 32'(grant), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_idx", 32'(grant_idx), 32'h0);
        check("mid_rst_valid", 32'(grant_valid), 32'h0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_after_grant", 32'(grant), 32'h1);
        check("mid_after_idx", 32'(grant_idx), 32'h0);

        // Release on the same edge the preempt condition would fire.
        do_reset();
        req = 4'b0011;
        step();
        check_inv("rel");
        for (int c = 0; c < 7; c++) begin
            step();
            check("rel_hold", 32'(grant), 32'h1);
            check_inv("rel");
        end
        req = 4'b0010;
        step();
        check("rel_grant", 32'(grant), 32'h2);
        check("rel_no_preempt", 32'(preempt), 32'h0);
        check_inv("rel");

        // Randomized sticky traffic against the reference model.
        do_reset();
        model_reset();
        req = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            r = req;
            step();
            model_edge(r);
            check_model();
            check_inv("rnd");
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
